// File: rtl/sobel_out_packer.sv
// Drains 8-bit Sobel pixels, packs 4 per 32-bit word tagged {eof,eol}, pushes to a 34-bit FIFO.
// Optional per-frame word checksum when SOBEL_PACK_SUM_EN is defined.
module sobel_out_packer #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  logic [7:0]  in_dout,
    input  logic        out_full,
    output logic        out_wr_en,
    output logic [33:0] out_din
`ifdef SOBEL_PACK_SUM_EN
    ,
    output logic [31:0] frame_sum,
    output logic        sum_valid
`endif
);

    localparam int COLS = WIDTH / 4;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_chk
        $error("sobel_out_packer: WIDTH must be a positive multiple of 4");
    end
    if (HEIGHT < 1) begin : g_height_chk
        $error("sobel_out_packer: HEIGHT must be >= 1");
    end

    typedef enum logic [0:0] {
        S_FILL  = 1'b0,
        S_WRITE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [23:0]     word_q, word_d;
    logic [33:0]     out_q, out_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            eol_s;
    logic            eof_s;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (in_rd_en && (lane_q == 2'd3)) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WRITE: begin
                if (!out_full) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // FIFO handshakes; reset_n gating keeps the upstream FIFO untouched while held in reset
    always_comb begin
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        case (state_q)
            S_FILL: begin
                in_rd_en = reset_n & ~in_empty;
            end
            S_WRITE: begin
                out_wr_en = ~out_full;
                in_rd_en  = reset_n & ~out_full & ~in_empty;
            end
            default: begin
                in_rd_en  = 1'b0;
                out_wr_en = 1'b0;
            end
        endcase
    end

    assign eol_s = (col_q == COL_LAST);
    assign eof_s = eol_s && (row_q == ROW_LAST);

    // Datapath next-state: byte lanes, output word/flags, line/frame counters
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        out_d  = out_q;
        col_d  = col_q;
        row_d  = row_q;
        if (state_q == S_FILL) begin
            if (in_rd_en) begin
                case (lane_q)
                    2'd0:    word_d[7:0]   = in_dout;
                    2'd1:    word_d[15:8]  = in_dout;
                    2'd2:    word_d[23:16] = in_dout;
                    2'd3:    out_d         = {eof_s, eol_s, in_dout, word_q};
                    default: word_d        = word_q;
                endcase
                lane_d = lane_q + 2'd1;
            end else begin
                lane_d = lane_q;
            end
        end else begin
            if (out_wr_en) begin
                if (eol_s) begin
                    col_d = {CW{1'b0}};
                    if (row_q == ROW_LAST) begin
                        row_d = {RW{1'b0}};
                    end else begin
                        row_d = row_q + {{(RW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    col_d = col_q + {{(CW-1){1'b0}}, 1'b1};
                end
                // Overlap the next word's first pixel with this push to avoid a bubble
                if (in_rd_en) begin
                    word_d[7:0] = in_dout;
                    lane_d      = 2'd1;
                end else begin
                    lane_d      = 2'd0;
                end
            end else begin
                lane_d = lane_q;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= 2'd0;
            word_q <= 24'd0;
            out_q  <= 34'd0;
            col_q  <= {CW{1'b0}};
            row_q  <= {RW{1'b0}};
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            out_q  <= out_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    assign out_din = out_q;

`ifdef SOBEL_PACK_SUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] frame_sum_q, frame_sum_d;
    logic        sum_valid_q, sum_valid_d;

    // Frame accumulator; the eof word closes the frame and restarts the sum
    always_comb begin
        acc_d       = acc_q;
        frame_sum_d = frame_sum_q;
        sum_valid_d = 1'b0;
        if (out_wr_en) begin
            if (out_q[33]) begin
                frame_sum_d = acc_q + out_q[31:0];
                acc_d       = 32'd0;
                sum_valid_d = 1'b1;
            end else begin
                acc_d       = acc_q + out_q[31:0];
            end
        end else begin
            sum_valid_d = 1'b0;
        end
    end

    // Accumulator registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= 32'd0;
            frame_sum_q <= 32'd0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign frame_sum = frame_sum_q;
    assign sum_valid = sum_valid_q;
`else
    // Checksum feature not built: no accumulator state.
`endif

endmodule

// File: tb/tb_sobel_out_packer.sv
// Directed bench for sobel_out_packer (WIDTH=8, HEIGHT=2) with a queue-based FIFO/packing model.
module tb_sobel_out_packer;

    localparam int W    = 8;
    localparam int H    = 2;
    localparam int COLS = W / 4;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_empty = 1'b1;
    logic [7:0]  in_dout  = 8'h00;
    logic        out_full = 1'b0;
    logic        in_rd_en;
    logic        out_wr_en;
    logic [33:0] out_din;
`ifdef SOBEL_PACK_SUM_EN
    logic [31:0] frame_sum;
    logic        sum_valid;
    logic [31:0] acc_m;
    logic [31:0] sum_m;
    bit          sum_due;
    int          sum_pulses;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  src[$];
    logic [7:0]  part[$];
    logic [33:0] exp_q[$];
    logic [33:0] log_q[$];
    int          widx  = 0;
    int          pops  = 0;
    int          cyc   = 0;
    bit          gap_en = 1'b0;

    sobel_out_packer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din)
`ifdef SOBEL_PACK_SUM_EN
        ,
        .frame_sum (frame_sum),
        .sum_valid (sum_valid)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [33:0] b2w(input logic b);
        return {33'd0, b};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive_inputs();
        in_empty = (src.size() == 0) || (gap_en && cyc[0]);
        in_dout  = (src.size() != 0) ? src[0] : 8'h00;
    endtask

    task automatic add_pixels(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) src.push_back(start + 8'(i));
        drive_inputs();
    endtask

    // One clock of model + comparison; entered and left just after a rising edge.
    task automatic step();
        bit   pend;
        bit   popped;
        int   col;
        int   row;
        logic eol;
        logic eof;
        @(negedge clock);
        pend = (exp_q.size() != 0);
        if (pend) begin
            chk("out_din", out_din, exp_q[0]);
            chk("out_wr_en", b2w(out_wr_en), b2w(!out_full));
            chk("in_rd_en", b2w(in_rd_en), b2w(!out_full && !in_empty));
        end else begin
            chk("out_wr_en_idle", b2w(out_wr_en), 34'd0);
            chk("in_rd_en_fill", b2w(in_rd_en), b2w(!in_empty));
        end
`ifdef SOBEL_PACK_SUM_EN
        chk("sum_valid", b2w(sum_valid), b2w(sum_due));
        if (sum_valid) sum_pulses++;
        if (sum_due) chk("frame_sum", {2'b00, frame_sum}, {2'b00, sum_m});
        sum_due = 1'b0;
`endif
        if (out_wr_en && pend) begin
            log_q.push_back(exp_q[0]);
`ifdef SOBEL_PACK_SUM_EN
            if (exp_q[0][33]) begin
                sum_m   = acc_m + exp_q[0][31:0];
                acc_m   = 32'd0;
                sum_due = 1'b1;
            end else begin
                acc_m = acc_m + exp_q[0][31:0];
            end
`endif
            void'(exp_q.pop_front());
        end
        popped = in_rd_en;
        if (in_rd_en) begin
            pops++;
            part.push_back(in_dout);
            if (part.size() == 4) begin
                col = widx % COLS;
                row = (widx / COLS) % H;
                eol = (col == COLS - 1);
                eof = eol && (row == H - 1);
                exp_q.push_back({eof, eol, part[3], part[2], part[1], part[0]});
                part.delete();
                widx++;
            end
        end
        @(posedge clock);
        #1;
        if (popped && src.size() != 0) void'(src.pop_front());
        cyc++;
        drive_inputs();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d cycles, expected < %0d", name, n, budget);
        end
        step();
        step();
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_out_wr_en", b2w(out_wr_en), 34'd0);
        chk("rst_out_din", out_din, 34'd0);
        chk("rst_in_rd_en", b2w(in_rd_en), 34'd0);
`ifdef SOBEL_PACK_SUM_EN
        chk("rst_frame_sum", {2'b00, frame_sum}, 34'd0);
        chk("rst_sum_valid", b2w(sum_valid), 34'd0);
        acc_m      = 32'd0;
        sum_m      = 32'd0;
        sum_due    = 1'b0;
        sum_pulses = 0;
`endif
        src.delete();
        part.delete();
        exp_q.delete();
        log_q.delete();
        widx = 0;
        pops = 0;
        drive_inputs();
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        int src_before;
        @(posedge clock);
        #1;
        do_reset();

        // Two words, no stalls
        add_pixels(8'h01, 8);
        run_idle("t1", 60);
        chk("t1_count", 34'(log_q.size()), 34'd2);
        chk("t1_w0", log_q[0], 34'h0_04030201);
        chk("t1_w1", log_q[1], 34'h1_08070605);

        // Full frame plus first word of next frame
        do_reset();
        add_pixels(8'h00, 20);
        run_idle("t2", 120);
        chk("t2_count", 34'(log_q.size()), 34'd5);
        chk("t2_w0", log_q[0], 34'h0_03020100);
        chk("t2_w1", log_q[1], 34'h1_07060504);
        chk("t2_w2", log_q[2], 34'h0_0B0A0908);
        chk("t2_w3", log_q[3], 34'h3_0F0E0D0C);
        chk("t2_w4", log_q[4], 34'h0_13121110);

        // Downstream backpressure with a word pending
        do_reset();
        out_full = 1'b1;
        add_pixels(8'h30, 8);
        n = 0;
        while (exp_q.size() == 0 && n < 40) begin
            step();
            n++;
        end
        chk("t3_pending", b2w(exp_q.size() != 0), 34'd1);
        repeat (10) step();
        chk("t3_no_push", 34'(log_q.size()), 34'd0);
        chk("t3_src_held", 34'(src.size()), 34'd4);
        out_full   = 1'b0;
        src_before = src.size();
        step();
        chk("t3_one_push", 34'(log_q.size()), 34'd1);
        chk("t3_same_cycle_pop", 34'(src.size()), 34'(src_before - 1));
        run_idle("t3", 60);
        chk("t3_w0", log_q[0], 34'h0_33323130);
        chk("t3_w1", log_q[1], 34'h1_37363534);

        // Upstream gaps every other cycle
        do_reset();
        gap_en = 1'b1;
        add_pixels(8'h20, 16);
        run_idle("t4", 200);
        gap_en = 1'b0;
        drive_inputs();
        chk("t4_count", 34'(log_q.size()), 34'd4);
        chk("t4_w0", log_q[0], 34'h0_23222120);
        chk("t4_w1", log_q[1], 34'h1_27262524);
        chk("t4_w3", log_q[3], 34'h3_2F2E2D2C);

        // Reset mid-frame after 6 pixels, then a clean frame
        do_reset();
        add_pixels(8'h40, 8);
        n = 0;
        while (pops < 6 && n < 40) begin
            step();
            n++;
        end
        chk("t5_pops", 34'(pops), 34'd6);
        chk("t5_in_empty", b2w(in_empty), 34'd0);
        do_reset();
        add_pixels(8'h50, 16);
        run_idle("t5", 120);
        chk("t5_count", 34'(log_q.size()), 34'd4);
        chk("t5_w0", log_q[0], 34'h0_53525150);
        chk("t5_w1", log_q[1], 34'h1_57565554);
        chk("t5_w3", log_q[3], 34'h3_5F5E5D5C);

`ifdef SOBEL_PACK_SUM_EN
        // Frame checksum
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(8'h01);
        drive_inputs();
        run_idle("t6", 120);
        chk("t6_w3", log_q[3], 34'h3_01010101);
        chk("t6_frame_sum", {2'b00, frame_sum}, 34'h0_04040404);
        chk("t6_pulses", 34'(sum_pulses), 34'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
